// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over a raster-ordered AXI4-Stream feature map.
// Even rows fold column pairs into a half-width row buffer; odd rows close each window.
module maxpool2x2_stream #(
  parameter int IN_HEIGHT  = 2,
  parameter int IN_WIDTH   = 2,
  parameter int CHANNELS   = 8,
  parameter int WORDS      = 2,
  parameter int WORD_WIDTH = 8
) (
  input  logic                        i_aclk,
  input  logic                        i_aresetn,
  input  logic                        i_tvalid,
  output logic                        o_tready,
  input  logic [WORDS*WORD_WIDTH-1:0] i_tdata,
  output logic                        o_tvalid,
  input  logic                        i_tready,
  output logic [WORDS*WORD_WIDTH-1:0] o_tdata,
  output logic                        o_tlast
);

  localparam int WIDTH  = WORDS * WORD_WIDTH;
  localparam int BEATS  = CHANNELS / WORDS;
  localparam int HALF_W = IN_WIDTH / 2;
  localparam int HALF_H = IN_HEIGHT / 2;
  localparam int DEPTH  = HALF_W * BEATS;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW     = $clog2(IN_WIDTH);
  localparam int RW     = $clog2(IN_HEIGHT);
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [BW-1:0] B_LAST = BW'(BEATS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(IN_WIDTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IN_HEIGHT - 1);

  // Per-lane unsigned maximum; lanes never interact.
  function automatic logic [WIDTH-1:0] lane_max(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int l = 0; l < WORDS; l++) begin
      m[WORD_WIDTH*l +: WORD_WIDTH] =
        (a[WORD_WIDTH*l +: WORD_WIDTH] > b[WORD_WIDTH*l +: WORD_WIDTH]) ?
        a[WORD_WIDTH*l +: WORD_WIDTH] : b[WORD_WIDTH*l +: WORD_WIDTH];
    end
    return m;
  endfunction

  logic [BW-1:0]    b_cnt;
  logic [CW-1:0]    c_cnt;
  logic [RW-1:0]    r_cnt;
  logic             accept;
  logic             in_win;
  logic             emit_p0;
  logic             last_p0;
  logic [AW-1:0]    rb_addr;
  logic [WIDTH-1:0] hmax_p0;
  logic [WIDTH-1:0] pool_p0;
  logic [WIDTH-1:0] hreg   [BEATS];
  logic [WIDTH-1:0] rowbuf [DEPTH];
  logic [WIDTH-1:0] data_p1;
  logic             vld_p1;
  logic             last_p1;

  // Stage p0: position decode and combinational window reduction of the incoming beat
  assign o_tready = !vld_p1 || i_tready;
  assign accept   = i_tvalid && o_tready;
  assign in_win   = (32'(c_cnt) < 32'(2 * HALF_W)) && (32'(r_cnt) < 32'(2 * HALF_H));
  assign rb_addr  = AW'(32'(c_cnt >> 1) * 32'(BEATS) + 32'(b_cnt));
  assign hmax_p0  = lane_max(hreg[b_cnt], i_tdata);
  assign pool_p0  = lane_max(rowbuf[rb_addr], hmax_p0);
  assign emit_p0  = accept && in_win && c_cnt[0] && r_cnt[0];
  assign last_p0  = (32'(r_cnt) == 32'(2 * HALF_H - 1)) &&
                    (32'(c_cnt) == 32'(2 * HALF_W - 1)) && (b_cnt == B_LAST);

  always_ff @(posedge i_aclk) begin
    if (accept && in_win) begin
      if (!c_cnt[0]) begin
        hreg[b_cnt] <= i_tdata;
      end else if (!r_cnt[0]) begin
        rowbuf[rb_addr] <= hmax_p0;
      end
    end
  end

  // Stage p1: output register; holds while the consumer stalls
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      b_cnt   <= '0;
      c_cnt   <= '0;
      r_cnt   <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      data_p1 <= '0;
    end else begin
      if (accept) begin
        if (b_cnt == B_LAST) begin
          b_cnt <= '0;
          if (c_cnt == C_LAST) begin
            c_cnt <= '0;
            r_cnt <= (r_cnt == R_LAST) ? '0 : r_cnt + RW'(1);
          end else begin
            c_cnt <= c_cnt + CW'(1);
          end
        end else begin
          b_cnt <= b_cnt + BW'(1);
        end
      end
      if (emit_p0) begin
        vld_p1  <= 1'b1;
        data_p1 <= pool_p0;
        last_p1 <= last_p0;
      end else if (i_tready) begin
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end
    end
  end

  assign o_tvalid = vld_p1;
  assign o_tdata  = data_p1;
  assign o_tlast  = last_p1;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream: three geometries share one clock and reset.
module tb_maxpool2x2_stream;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  logic       a_ivalid, a_oready, a_ovalid, a_iready, a_olast;
  logic [7:0] a_idata, a_odata;
  logic       b_ivalid, b_oready, b_ovalid, b_iready, b_olast;
  logic [7:0] b_idata, b_odata;
  logic        c_ivalid, c_oready, c_ovalid, c_iready, c_olast;
  logic [15:0] c_idata, c_odata;

  maxpool2x2_stream #(.IN_HEIGHT(4), .IN_WIDTH(4), .CHANNELS(1), .WORDS(1), .WORD_WIDTH(8)) u_a (
    .i_aclk(clk), .i_aresetn(rst_n), .i_tvalid(a_ivalid), .o_tready(a_oready),
    .i_tdata(a_idata), .o_tvalid(a_ovalid), .i_tready(a_iready), .o_tdata(a_odata),
    .o_tlast(a_olast));

  maxpool2x2_stream #(.IN_HEIGHT(5), .IN_WIDTH(5), .CHANNELS(1), .WORDS(1), .WORD_WIDTH(8)) u_b (
    .i_aclk(clk), .i_aresetn(rst_n), .i_tvalid(b_ivalid), .o_tready(b_oready),
    .i_tdata(b_idata), .o_tvalid(b_ovalid), .i_tready(b_iready), .o_tdata(b_odata),
    .o_tlast(b_olast));

  maxpool2x2_stream #(.IN_HEIGHT(2), .IN_WIDTH(2), .CHANNELS(4), .WORDS(2), .WORD_WIDTH(8)) u_c (
    .i_aclk(clk), .i_aresetn(rst_n), .i_tvalid(c_ivalid), .o_tready(c_oready),
    .i_tdata(c_idata), .o_tvalid(c_ovalid), .i_tready(c_iready), .o_tdata(c_odata),
    .o_tlast(c_olast));

  task automatic test_reset();
    rst_n = 1'b0;
    a_ivalid = 1'b0; b_ivalid = 1'b0; c_ivalid = 1'b0;
    a_iready = 1'b1; b_iready = 1'b1; c_iready = 1'b1;
    a_idata = '0; b_idata = '0; c_idata = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (a_ovalid !== 1'b0) begin bad++; $display("FAIL reset_a_valid got=%b want=0", a_ovalid); end
    total++; if (a_olast !== 1'b0) begin bad++; $display("FAIL reset_a_last got=%b want=0", a_olast); end
    total++; if (a_odata !== 8'h00) begin bad++; $display("FAIL reset_a_data got=%0h want=0", a_odata); end
    total++; if (a_oready !== 1'b1) begin bad++; $display("FAIL reset_a_ready got=%b want=1", a_oready); end
    total++; if (b_ovalid !== 1'b0) begin bad++; $display("FAIL reset_b_valid got=%b want=0", b_ovalid); end
    total++; if (b_oready !== 1'b1) begin bad++; $display("FAIL reset_b_ready got=%b want=1", b_oready); end
    total++; if (c_ovalid !== 1'b0) begin bad++; $display("FAIL reset_c_valid got=%b want=0", c_ovalid); end
    total++; if (c_odata !== 16'h0000) begin bad++; $display("FAIL reset_c_data got=%0h want=0", c_odata); end
    total++; if (c_oready !== 1'b1) begin bad++; $display("FAIL reset_c_ready got=%b want=1", c_oready); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Inputs 0..15: each window max is its bottom-right value, emitted right after that beat.
  task automatic test_pool_4x4();
    logic exp_v;
    for (int k = 0; k < 16; k++) begin
      a_ivalid = 1'b1;
      a_idata  = 8'(k);
      @(posedge clk);
      #1;
      exp_v = (k == 5) || (k == 7) || (k == 13) || (k == 15);
      total++; if (a_ovalid !== exp_v) begin bad++; $display("FAIL pool4_valid k=%0d got=%b want=%b", k, a_ovalid, exp_v); end
      if (exp_v) begin
        total++; if (a_odata !== 8'(k)) begin bad++; $display("FAIL pool4_data k=%0d got=%0d want=%0d", k, a_odata, k); end
        total++; if (a_olast !== (k == 15)) begin bad++; $display("FAIL pool4_last k=%0d got=%b want=%b", k, a_olast, (k == 15)); end
      end
    end
    a_ivalid = 1'b0;
    @(posedge clk);
    #1;
    total++; if (a_ovalid !== 1'b0) begin bad++; $display("FAIL pool4_drain got=%b want=0", a_ovalid); end
  endtask

  // Two 5x5 images back to back; trailing column and row are dropped.
  task automatic test_odd_5x5();
    logic exp_v;
    int   loc;
    for (int j = 0; j < 50; j++) begin
      total++; if (b_oready !== 1'b1) begin bad++; $display("FAIL odd5_ready j=%0d got=%b want=1", j, b_oready); end
      b_ivalid = 1'b1;
      b_idata  = 8'(j);
      @(posedge clk);
      #1;
      loc   = j % 25;
      exp_v = (loc == 6) || (loc == 8) || (loc == 16) || (loc == 18);
      total++; if (b_ovalid !== exp_v) begin bad++; $display("FAIL odd5_valid j=%0d got=%b want=%b", j, b_ovalid, exp_v); end
      if (exp_v) begin
        total++; if (b_odata !== 8'(j)) begin bad++; $display("FAIL odd5_data j=%0d got=%0d want=%0d", j, b_odata, j); end
        total++; if (b_olast !== (loc == 18)) begin bad++; $display("FAIL odd5_last j=%0d got=%b want=%b", j, b_olast, (loc == 18)); end
      end
    end
    b_ivalid = 1'b0;
    @(posedge clk);
    #1;
    total++; if (b_ovalid !== 1'b0) begin bad++; $display("FAIL odd5_drain got=%b want=0", b_ovalid); end
  endtask

  // Two beats per pixel, two lanes per beat, data packed {hi,lo}.
  task automatic test_multi_beat();
    logic [15:0] beats [8];
    beats = '{16'h0901, 16'h000A, 16'h0802, 16'h0A00,
              16'h0703, 16'h0505, 16'h0604, 16'h0406};
    for (int k = 0; k < 8; k++) begin
      c_ivalid = 1'b1;
      c_idata  = beats[k];
      @(posedge clk);
      #1;
      total++; if (c_ovalid !== (k >= 6)) begin bad++; $display("FAIL multi_valid k=%0d got=%b want=%b", k, c_ovalid, (k >= 6)); end
      if (k == 6) begin
        total++; if (c_odata !== 16'h0904) begin bad++; $display("FAIL multi_data0 got=%h want=0904", c_odata); end
        total++; if (c_olast !== 1'b0) begin bad++; $display("FAIL multi_last0 got=%b want=0", c_olast); end
      end
      if (k == 7) begin
        total++; if (c_odata !== 16'h0A0A) begin bad++; $display("FAIL multi_data1 got=%h want=0a0a", c_odata); end
        total++; if (c_olast !== 1'b1) begin bad++; $display("FAIL multi_last1 got=%b want=1", c_olast); end
      end
    end
    c_ivalid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic exp_v;
    for (int k = 0; k < 6; k++) begin
      a_ivalid = 1'b1;
      a_idata  = 8'(k);
      @(posedge clk);
      #1;
    end
    total++; if (a_ovalid !== 1'b1 || a_odata !== 8'd5) begin bad++; $display("FAIL bp_first got=%b/%0d want=1/5", a_ovalid, a_odata); end
    a_iready = 1'b0;
    a_idata  = 8'd6;
    #1;
    total++; if (a_oready !== 1'b0) begin bad++; $display("FAIL bp_block got=%b want=0", a_oready); end
    for (int s = 0; s < 3; s++) begin
      @(posedge clk);
      #1;
      total++; if (a_ovalid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid s=%0d got=%b want=1", s, a_ovalid); end
      total++; if (a_odata !== 8'd5) begin bad++; $display("FAIL bp_hold_data s=%0d got=%0d want=5", s, a_odata); end
      total++; if (a_oready !== 1'b0) begin bad++; $display("FAIL bp_hold_ready s=%0d got=%b want=0", s, a_oready); end
    end
    a_iready = 1'b1;
    @(posedge clk);
    #1;
    total++; if (a_ovalid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b want=0", a_ovalid); end
    for (int k = 7; k < 16; k++) begin
      a_idata = 8'(k);
      @(posedge clk);
      #1;
      exp_v = (k == 7) || (k == 13) || (k == 15);
      total++; if (a_ovalid !== exp_v) begin bad++; $display("FAIL bp_valid k=%0d got=%b want=%b", k, a_ovalid, exp_v); end
      if (exp_v) begin
        total++; if (a_odata !== 8'(k)) begin bad++; $display("FAIL bp_data k=%0d got=%0d want=%0d", k, a_odata, k); end
      end
    end
    a_ivalid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unsigned();
    logic [7:0] tbl  [16];
    logic [7:0] want [4];
    int         idx;
    tbl  = '{8'h80, 8'h7F, 8'hFF, 8'h80,
             8'h01, 8'hFF, 8'h7F, 8'h01,
             8'h00, 8'h10, 8'h20, 8'h30,
             8'h05, 8'h04, 8'h03, 8'h02};
    want = '{8'hFF, 8'hFF, 8'h10, 8'h30};
    idx  = 0;
    for (int k = 0; k < 16; k++) begin
      a_ivalid = 1'b1;
      a_idata  = tbl[k];
      @(posedge clk);
      #1;
      if (k == 5 || k == 7 || k == 13 || k == 15) begin
        total++; if (a_ovalid !== 1'b1) begin bad++; $display("FAIL uns_valid k=%0d got=%b want=1", k, a_ovalid); end
        total++; if (a_odata !== want[idx]) begin bad++; $display("FAIL uns_data k=%0d got=%h want=%h", k, a_odata, want[idx]); end
        idx++;
      end
    end
    a_ivalid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    logic exp_v;
    for (int k = 0; k < 6; k++) begin
      a_ivalid = 1'b1;
      a_idata  = 8'(k);
      @(posedge clk);
      #1;
    end
    total++; if (a_ovalid !== 1'b1 || a_odata !== 8'd5) begin bad++; $display("FAIL ar_pre got=%b/%0d want=1/5", a_ovalid, a_odata); end
    a_ivalid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (a_ovalid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b want=0", a_ovalid); end
    total++; if (a_olast !== 1'b0) begin bad++; $display("FAIL ar_last got=%b want=0", a_olast); end
    total++; if (a_odata !== 8'h00) begin bad++; $display("FAIL ar_data got=%0h want=0", a_odata); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) begin
      a_ivalid = 1'b1;
      a_idata  = 8'(k);
      @(posedge clk);
      #1;
      exp_v = (k == 5) || (k == 7) || (k == 13) || (k == 15);
      total++; if (a_ovalid !== exp_v) begin bad++; $display("FAIL ar_valid2 k=%0d got=%b want=%b", k, a_ovalid, exp_v); end
      if (exp_v) begin
        total++; if (a_odata !== 8'(k)) begin bad++; $display("FAIL ar_data2 k=%0d got=%0d want=%0d", k, a_odata, k); end
        total++; if (a_olast !== (k == 15)) begin bad++; $display("FAIL ar_last2 k=%0d got=%b want=%b", k, a_olast, (k == 15)); end
      end
    end
    a_ivalid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_pool_4x4();
    test_odd_5x5();
    test_multi_beat();
    test_backpressure();
    test_unsigned();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
